// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: data width, canonical NOP, fetch FSM states and
// the FIFO entry that pairs an instruction with its PC.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// ROM and core-facing signals of the fetch stage; master is the fetch unit.
interface fetch_unit_if import cpu_pkg::*; #(
  parameter int ADDR_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [XLEN-1:0]       rom_q;
  logic [XLEN-1:0]       instr;
  logic [XLEN-1:0]       instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  redirect;
  logic [XLEN-1:0]       redirect_pc;
  logic                  halted;

  modport master (
    output rom_addr, instr, instr_pc, instr_valid, halted,
    input  rom_q, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  rom_addr, instr, instr_pc, instr_valid, halted,
    output rom_q, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush overrides push and pop.
module fetch_fifo import cpu_pkg::*; #(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic            do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues ROM reads, tracks the single in-flight read and
// buffers {pc, instr} for the core; supports redirect and halts after LAST_PC.
module fetch_unit import cpu_pkg::*; #(
  parameter int              ADDR_WIDTH = 3,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0,
  parameter logic [XLEN-1:0] LAST_PC    = 32'h7
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc, inflight_pc;
  logic            inflight;

  fetch_entry_t    head, wdata;
  logic [CW-1:0]   count;
  logic            empty, full, pop, push, issue, drain_done;
  logic [CW:0]     occ;

  assign pop   = ~empty & bus.instr_ready;
  assign push  = inflight;
  assign wdata = '{pc: inflight_pc, instr: bus.rom_q};

  // Slots already claimed once this cycle's push/pop settle; an issue may
  // only proceed if its data is guaranteed a free slot on arrival.
  assign occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue = (state == RUN) && !bus.redirect && (occ < (CW+1)'(FIFO_DEPTH));

  // Evaluated on next-cycle occupancy so halted rises right after the last pop.
  assign drain_done = !inflight && (count == CW'(pop));

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .wdata (wdata),
    .head  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign bus.rom_addr    = fetch_pc[ADDR_WIDTH-1:0];
  assign bus.instr_valid = ~empty;
  assign bus.instr       = empty ? '0 : head.instr;
  assign bus.instr_pc    = empty ? '0 : head.pc;
  assign bus.halted      = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.redirect) begin
      state    <= RUN;
      fetch_pc <= bus.redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= fetch_pc;
      case (state)
        RUN: begin
          if (issue) begin
            if (fetch_pc == LAST_PC) state    <= DRAIN;
            else                     fetch_pc <= fetch_pc + 1'b1;
          end
        end
        DRAIN:   if (drain_done) state <= HALT;
        HALT:    ;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !pop) assert (!full);
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a delivered-stream scoreboard checks every
// cycle, and literal expectations pin the cycle timing.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] LAST_PC  = 32'h7;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] rom [8];

  fetch_unit_if #(.ADDR_WIDTH(3)) bus ();

  fetch_unit #(.ADDR_WIDTH(3), .FIFO_DEPTH(2), .RESET_PC(RESET_PC), .LAST_PC(LAST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_q <= rom[bus.rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: the core must see consecutive PCs starting at the last reset or
  // redirect target, each with its ROM word, ending with LAST_PC, after
  // which the unit reports halted with nothing valid.
  logic [31:0] m_pc;
  logic        m_done, m_flush, m_hold, m_prev_rst, m_armed = 1'b0;
  logic [31:0] h_pc, h_instr;

  always @(negedge clk) begin
    if (rst) begin
      m_pc = RESET_PC; m_done = 1'b0; m_flush = 1'b0; m_hold = 1'b0;
      m_prev_rst = 1'b1; m_armed = 1'b1;
    end else if (m_armed) begin
      if (m_prev_rst) begin
        chk("rst_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_pc", bus.instr_pc, 32'h0);
        chk("rst_addr", 32'(bus.rom_addr), 32'(RESET_PC[2:0]));
      end
      chk("halted", 32'(bus.halted), 32'(m_done));
      if (m_flush || m_done) chk("valid_idle", 32'(bus.instr_valid), 32'h0);
      if (m_done) chk("halt_addr", 32'(bus.rom_addr), 32'(LAST_PC[2:0]));
      if (!bus.instr_valid) begin
        chk("empty_instr", bus.instr, 32'h0);
        chk("empty_pc", bus.instr_pc, 32'h0);
      end
      if (m_hold) begin
        chk("hold_valid", 32'(bus.instr_valid), 32'h1);
        chk("hold_pc", bus.instr_pc, h_pc);
        chk("hold_instr", bus.instr, h_instr);
      end
      m_prev_rst = 1'b0;
      if (bus.redirect) begin
        m_pc = bus.redirect_pc; m_done = 1'b0; m_flush = 1'b1; m_hold = 1'b0;
      end else begin
        m_flush = 1'b0;
        if (bus.instr_valid && bus.instr_ready) begin
          chk("pop_pc", bus.instr_pc, m_pc);
          chk("pop_instr", bus.instr, rom[m_pc[2:0]]);
          if (m_pc == LAST_PC) m_done = 1'b1;
          m_pc = m_pc + 1;
        end
        m_hold  = bus.instr_valid && !bus.instr_ready;
        h_pc    = bus.instr_pc;
        h_instr = bus.instr;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Leaves the bench in cycle 0 (first cycle with rst low).
  task automatic start();
    rst = 1'b1; bus.instr_ready = 1'b0; bus.redirect = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 40 && !bus.halted; i++) tick();
    chk("halt_wait", 32'(bus.halted), 32'h1);
  endtask

  task automatic chk_head(input string name, input logic [31:0] pc);
    chk({name, "_v"}, 32'(bus.instr_valid), 32'h1);
    chk({name, "_pc"}, bus.instr_pc, pc);
    chk({name, "_ins"}, bus.instr, rom[pc[2:0]]);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = NOP + (32'(i) << 12) + 32'h0A00_0000;
    rst = 1'b1; bus.instr_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;

    // Streaming, ready held high
    start(); bus.instr_ready = 1'b1;
    chk("t1_c0_valid", 32'(bus.instr_valid), 32'h0);
    chk("t1_c0_addr", 32'(bus.rom_addr), 32'h0);
    tick();
    chk("t1_c1_valid", 32'(bus.instr_valid), 32'h0);
    chk("t1_c1_addr", 32'(bus.rom_addr), 32'h1);
    tick(); chk_head("t1_c2", 32'h0);
    repeat (7) tick(); chk_head("t1_c9", 32'h7);
    tick();
    chk("t1_c10_halt", 32'(bus.halted), 32'h1);
    chk("t1_c10_addr", 32'(bus.rom_addr), 32'h7);
    tick(); chk("t1_c11_addr", 32'(bus.rom_addr), 32'h7);

    // Backpressure cycles 0-9
    start();
    repeat (9) tick();
    chk_head("t2_c9", 32'h0);
    chk("t2_c9_addr", 32'(bus.rom_addr), 32'h2);
    tick(); bus.instr_ready = 1'b1; chk_head("t2_c10", 32'h0);
    tick(); chk_head("t2_c11", 32'h1);
    tick(); chk_head("t2_c12", 32'h2);
    wait_halt();

    // Redirect to 5 in cycle 4 with data buffered and a read in flight
    start(); bus.instr_ready = 1'b1;
    repeat (4) tick();
    chk_head("t3_c4", 32'h2);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h5;
    tick(); bus.redirect = 1'b0;
    chk("t3_c5_valid", 32'(bus.instr_valid), 32'h0);
    chk("t3_c5_addr", 32'(bus.rom_addr), 32'h5);
    tick(); chk("t3_c6_valid", 32'(bus.instr_valid), 32'h0);
    tick(); chk_head("t3_c7", 32'h5);
    tick(); chk_head("t3_c8", 32'h6);
    tick(); chk_head("t3_c9", 32'h7);
    tick(); chk("t3_c10_halt", 32'(bus.halted), 32'h1);

    // Redirect out of HALT
    bus.redirect = 1'b1; bus.redirect_pc = 32'h2;
    tick(); bus.redirect = 1'b0;
    chk("t4_halt_drop", 32'(bus.halted), 32'h0);
    tick(); tick(); chk_head("t4_first", 32'h2);
    wait_halt();

    // Redirect coinciding with a pop
    start();
    repeat (3) tick();
    chk_head("t5_c3", 32'h0);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h6; bus.instr_ready = 1'b1;
    tick(); bus.redirect = 1'b0;
    chk("t5_c4_valid", 32'(bus.instr_valid), 32'h0);
    tick(); tick(); chk_head("t5_c6", 32'h6);
    wait_halt();

    // Reset mid-stream in cycle 6
    start(); bus.instr_ready = 1'b1;
    repeat (6) tick();
    chk_head("t6_c6", 32'h4);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("t6_valid", 32'(bus.instr_valid), 32'h0);
    chk("t6_halt", 32'(bus.halted), 32'h0);
    tick(); tick(); chk_head("t6_restart", RESET_PC);
    wait_halt();

    // PC wrap at 2^32 and ROM index wrap
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE;
    tick(); bus.redirect = 1'b0;
    tick(); tick(); chk_head("t7_first", 32'hFFFF_FFFE);
    tick(); chk_head("t7_second", 32'hFFFF_FFFF);
    tick(); chk_head("t7_third", 32'h0);
    wait_halt();

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
